sym_dn_lut_loader: RTL and testbench



---
 rtl/sym_dn_lut_loader.sv | 158 +++++++++++++++
 tb/tb_sym_dn_lut_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sym_dn_lut_loader.sv
// Write-side loader for the two-bank symmetric decision-node rank LUT.
// Optional parity check on update words: define SYM_DN_LOADER_PARITY_EN.
module sym_dn_lut_loader #(
    parameter int ENTRY_ADDR      = 5,
    parameter int MULTI_FRAME_NUM = 2
) (
    input  logic                                             write_clk,
    input  logic                                             rst,
    input  logic                                             load_start,
    input  logic                                             load_offset,
    input  logic                                             load_abort,
    input  logic                                             upd_valid,
    input  logic [1:0]                                       upd_data,
`ifdef SYM_DN_LOADER_PARITY_EN
    input  logic                                             upd_parity,
    output logic                                             parity_err,
`endif
    output logic                                             upd_ready,
    output logic                                             lut_in_bank0,
    output logic                                             lut_in_bank1,
    output logic [ENTRY_ADDR-$clog2(MULTI_FRAME_NUM)-1:0]    page_write_addr,
    output logic                                             write_addr_offset,
    output logic                                             we,
    output logic                                             active_offset,
    output logic                                             busy,
    output logic                                             load_done,
    output logic                                             load_err
);

    localparam int PAGE_ADDR_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);
    localparam int PAGE_DEPTH  = 2 ** PAGE_ADDR_W;
    localparam logic [PAGE_ADDR_W-1:0] LAST_ADDR = PAGE_ADDR_W'(PAGE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PAGE_ADDR_W-1:0] cnt_q, cnt_d;
    logic [PAGE_ADDR_W-1:0] addr_q, addr_d;
    logic                   tgt_q, tgt_d;
    logic                   active_q, active_d;
    logic                   we_q, we_d;
    logic                   b0_q, b0_d;
    logic                   b1_q, b1_d;
    logic                   woff_q, woff_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   par_err_q, par_err_d;
    logic                   par_bad;
    logic                   hs;

    assign upd_ready         = (state_q == LOAD);
    assign busy              = (state_q != IDLE);
    assign hs                = upd_valid & upd_ready;
    assign we                = we_q;
    assign lut_in_bank0      = b0_q;
    assign lut_in_bank1      = b1_q;
    assign page_write_addr   = addr_q;
    assign write_addr_offset = woff_q;
    assign active_offset     = active_q;
    assign load_done         = done_q;
    assign load_err          = err_q;

`ifdef SYM_DN_LOADER_PARITY_EN
    assign par_bad    = hs & (upd_parity != ^upd_data);
    assign parity_err = par_err_q;
`else
    assign par_bad    = 1'b0;
`endif

    // Next-state, write-port and status pulse computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        active_d  = active_q;
        addr_d    = addr_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        woff_d    = woff_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        par_err_d = par_err_q | par_bad;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (load_offset != active_q) begin
                        tgt_d     = load_offset;
                        cnt_d     = '0;
                        par_err_d = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (load_abort || par_bad) begin
                    state_d = IDLE;
                end else if (hs) begin
                    we_d   = 1'b1;
                    b0_d   = upd_data[0];
                    b1_d   = upd_data[1];
                    addr_d = cnt_q;
                    woff_d = tgt_q;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                active_d = tgt_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tgt_q     <= 1'b0;
            active_q  <= 1'b0;
            addr_q    <= '0;
            b0_q      <= 1'b0;
            b1_q      <= 1'b0;
            woff_q    <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            active_q  <= active_d;
            addr_q    <= addr_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            woff_q    <= woff_d;
            we_q      <= we_d;
            done_q    <= done_d;
            err_q     <= err_d;
            par_err_q <= par_err_d;
        end
    end

endmodule

// File: tb/tb_sym_dn_lut_loader.sv
// Scoreboard bench for sym_dn_lut_loader.
// Expected writes are queued at drive time and popped on each we pulse.
module tb_sym_dn_lut_loader;

    logic       write_clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       load_offset = 1'b0;
    logic       load_abort = 1'b0;
    logic       upd_valid = 1'b0;
    logic [1:0] upd_data = 2'b00;
    logic       upd_ready;
    logic       lut_in_bank0;
    logic       lut_in_bank1;
    logic [3:0] page_write_addr;
    logic       write_addr_offset;
    logic       we;
    logic       active_offset;
    logic       busy;
    logic       load_done;
    logic       load_err;
`ifdef SYM_DN_LOADER_PARITY_EN
    logic       upd_parity = 1'b0;
    logic       parity_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_we   = 0;
    logic [6:0] exp_q[$];

    sym_dn_lut_loader dut (
        .write_clk        (write_clk),
        .rst              (rst),
        .load_start       (load_start),
        .load_offset      (load_offset),
        .load_abort       (load_abort),
        .upd_valid        (upd_valid),
        .upd_data         (upd_data),
`ifdef SYM_DN_LOADER_PARITY_EN
        .upd_parity       (upd_parity),
        .parity_err       (parity_err),
`endif
        .upd_ready        (upd_ready),
        .lut_in_bank0     (lut_in_bank0),
        .lut_in_bank1     (lut_in_bank1),
        .page_write_addr  (page_write_addr),
        .write_addr_offset(write_addr_offset),
        .we               (we),
        .active_offset    (active_offset),
        .busy             (busy),
        .load_done        (load_done),
        .load_err         (load_err)
    );

    always #5 write_clk = ~write_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Write-port monitor: every we pulse must match the queue head.
    always @(negedge write_clk) begin
        if (load_done) n_done++;
        if (load_err) n_err++;
        if (we === 1'b1) begin
            n_we++;
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 32'd1, 32'd0);
            end else begin
                chk("wr", {write_addr_offset, page_write_addr,
                           lut_in_bank1, lut_in_bank0}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic start(input logic off);
        load_start  = 1'b1;
        load_offset = off;
        tick();
        load_start  = 1'b0;
    endtask

    // Drive one word for one cycle; push expectation if it should land.
    task automatic send(input logic off, input logic [3:0] a,
                        input logic [1:0] d, input logic bad,
                        input logic push);
        upd_valid = 1'b1;
        upd_data  = d;
`ifdef SYM_DN_LOADER_PARITY_EN
        upd_parity = (^d) ^ bad;
`else
        if (bad) chk("parity_unsupported", 32'd1, 32'd0);
`endif
        if (push) exp_q.push_back({off, a, d});
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic full_load(input logic off, input logic gap);
        int d0;
        d0 = n_done;
        start(off);
        for (int i = 0; i < 16; i++) begin
            send(off, 4'(i), 2'(i % 4), 1'b0, 1'b1);
            if (gap && i != 15) tick();
        end
        @(negedge write_clk);
        chk("done_early", 32'(load_done), 32'd0);
        chk("commit_busy", 32'(busy), 32'd1);
        @(negedge write_clk);
        chk("done_pulse", 32'(load_done), 32'd1);
        chk("active_new", 32'(active_offset), 32'(off));
        @(negedge write_clk);
        chk("done_once", 32'(n_done - d0), 32'd1);
        chk("q_drained", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        int e0;
        int d0;
        int w0;
        tick();
        tick();
        @(negedge write_clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active", 32'(active_offset), 32'd0);
        rst = 1'b0;
        tick();

        // Full load to offset 1, valid held high.
        w0 = n_we;
        full_load(1'b1, 1'b0);
        chk("we_count1", 32'(n_we - w0), 32'd16);

        // Rejected start on live page.
        e0 = n_err;
        start(1'b1);
        @(negedge write_clk);
        chk("err_pulse", 32'(load_err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_active", 32'(active_offset), 32'd1);
        @(negedge write_clk);
        chk("err_once", 32'(n_err - e0), 32'd1);
        #1;

        // Load to offset 0 with gapped valid.
        full_load(1'b0, 1'b1);

        // Abort after 7 handshakes; eighth word not written.
        d0 = n_done;
        w0 = n_we;
        start(1'b1);
        for (int i = 0; i < 7; i++) send(1'b1, 4'(i), 2'(i % 4), 1'b0, 1'b1);
        load_abort = 1'b1;
        send(1'b1, 4'd7, 2'd3, 1'b0, 1'b0);
        load_abort = 1'b0;
        @(negedge write_clk);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge write_clk);
        chk("abort_we_count", 32'(n_we - w0), 32'd7);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_active", 32'(active_offset), 32'd0);
        chk("abort_q", 32'(exp_q.size()), 32'd0);
        #1;

        // Reset at handshake 10 of a load.
        start(1'b1);
        for (int i = 0; i < 9; i++) send(1'b1, 4'(i), 2'(i % 4), 1'b0, 1'b1);
        rst = 1'b1;
        send(1'b1, 4'd9, 2'd1, 1'b0, 1'b0);
        @(negedge write_clk);
        chk("rst2_outs", {we, busy, upd_ready, active_offset, load_done,
                          load_err, write_addr_offset, lut_in_bank1,
                          lut_in_bank0, page_write_addr}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        full_load(1'b1, 1'b0);

`ifdef SYM_DN_LOADER_PARITY_EN
        // Bad parity on word 3 aborts after 3 writes.
        d0 = n_done;
        w0 = n_we;
        start(1'b0);
        for (int i = 0; i < 3; i++) send(1'b0, 4'(i), 2'(i % 4), 1'b0, 1'b1);
        send(1'b0, 4'd3, 2'd3, 1'b1, 1'b0);
        @(negedge write_clk);
        chk("par_err_set", 32'(parity_err), 32'd1);
        chk("par_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge write_clk);
        chk("par_we_count", 32'(n_we - w0), 32'd3);
        chk("par_no_done", 32'(n_done - d0), 32'd0);
        #1;
        start(1'b0);
        @(negedge write_clk);
        chk("par_err_clr", 32'(parity_err), 32'd0);
        #1;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
`endif

        repeat (2) tick();
        chk("final_q", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
